// File: rtl/lab3_cache_pkg.sv
// Shared types and constants for the lab3 cache write-back path.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package lab3_cache_pkg;

    localparam int LINE_WORDS     = 16;
    localparam int LINE_BITS      = 512;
    localparam int OFFSET_BITS    = 6;
    localparam int LINE_ADDR_BITS = 32 - OFFSET_BITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } wbb_state_e;

    typedef struct packed {
        logic                      valid;
        logic [LINE_ADDR_BITS-1:0] line_addr;
        logic [LINE_BITS-1:0]      data;
    } wbb_entry_t;

    localparam logic [2:0] MEM_TYPE_READ  = 3'd0;
    localparam logic [2:0] MEM_TYPE_WRITE = 3'd1;

    // 77-bit memory request: type, opaque tag, byte address, length, data
    typedef struct packed {
        logic [2:0]  type_;
        logic [7:0]  opaque;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_req_4B_t;

    // 47-bit memory response: type, opaque tag, test bits, length, data
    typedef struct packed {
        logic [2:0]  type_;
        logic [7:0]  opaque;
        logic [1:0]  test;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_resp_4B_t;

endpackage

// File: rtl/lab3_cache_wbb_entry_file.sv
// Victim line storage: DEPTH entries, one write port, head read, parallel line-address compare.
// Latency: write visible next cycle; head read and compare are combinational.
// Backpressure: none; the caller guarantees it never writes a valid slot. Forwarding under LAB3_CACHE_WBB_FORWARD_EN.
module lab3_cache_wbb_entry_file
    import lab3_cache_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int PTR_W = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr_en_i,
    input  logic [PTR_W-1:0]          wr_ptr_i,
    input  logic [LINE_ADDR_BITS-1:0] wr_line_i,
    input  logic [LINE_BITS-1:0]      wr_data_i,
    input  logic                      clr_en_i,
    input  logic [PTR_W-1:0]          head_ptr_i,
    output wbb_entry_t                head_o,
    input  logic [LINE_ADDR_BITS-1:0] chk_line_i,
    output logic                      chk_hit_o
`ifdef LAB3_CACHE_WBB_FORWARD_EN
    ,
    output logic [LINE_BITS-1:0]      fwd_data_o
`endif
);

    wbb_entry_t ent_q [DEPTH];

    // Only the valid bits need reset; payload is qualified by valid everywhere
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i].valid <= 1'b0;
            end
        end else begin
            if (clr_en_i) begin
                ent_q[head_ptr_i].valid <= 1'b0;
            end
            if (wr_en_i) begin
                ent_q[wr_ptr_i] <= '{valid: 1'b1, line_addr: wr_line_i, data: wr_data_i};
            end
        end
    end

    assign head_o = ent_q[head_ptr_i];

    // Any valid entry holding the probed line, including one still waiting on acks
    always_comb begin
        chk_hit_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_q[i].valid && (ent_q[i].line_addr == chk_line_i)) begin
                chk_hit_o = 1'b1;
            end
        end
    end

`ifdef LAB3_CACHE_WBB_FORWARD_EN
    logic [PTR_W-1:0] idx;

    // Walk oldest to newest from head so the youngest matching copy wins
    always_comb begin
        fwd_data_o = '0;
        idx        = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = PTR_W'((int'(head_ptr_i) + k) % DEPTH);
            if (ent_q[idx].valid && (ent_q[idx].line_addr == chk_line_i)) begin
                fwd_data_o = ent_q[idx].data;
            end
        end
    end
`endif

endmodule

// File: rtl/lab3_cache_writeback_buffer.sv
// Victim write-back buffer: takes a whole dirty line per cycle, drains it as 16 word writes, retires on 16 acks.
// Latency: first write request is offered the cycle after enqueue, then one per cycle while memreq_rdy is high.
// Backpressure: evict_rdy drops when all entries are full; memreq stalls hold the message; optional LAB3_CACHE_WBB_FORWARD_EN.
module lab3_cache_writeback_buffer
    import lab3_cache_pkg::*;
#(
    parameter int DEPTH           = 2,
    parameter int MAX_OUTSTANDING = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 evict_val,
    output logic                 evict_rdy,
    input  logic [31:0]          evict_addr,
    input  logic [LINE_BITS-1:0] evict_data,
    output logic                 memreq_val,
    input  logic                 memreq_rdy,
    output mem_req_4B_t          memreq_msg,
    input  logic                 memresp_val,
    output logic                 memresp_rdy,
    input  mem_resp_4B_t         memresp_msg,
    input  logic [31:0]          check_addr,
    output logic                 check_hit,
    output logic                 empty
`ifdef LAB3_CACHE_WBB_FORWARD_EN
    ,
    output logic                 fwd_val,
    output logic [LINE_BITS-1:0] fwd_data
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    wbb_state_e       state_q, state_d;
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [4:0]       send_idx_q, send_idx_d;
    logic [4:0]       ack_cnt_q, ack_cnt_d;
    logic [4:0]       outst_q, outst_d;

    wbb_entry_t head_ent;
    logic       enq, fire, ack_ok, retire, can_send;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (int'(p) == DEPTH - 1) ? '0 : p + PTR_W'(1);
    endfunction

    assign evict_rdy   = (count_q < CNT_W'(DEPTH));
    assign enq         = evict_val && evict_rdy;
    assign fire        = memreq_val && memreq_rdy;
    assign memresp_rdy = 1'b1;
    // Non-write responses and acks with nothing in flight (e.g. after reset) are dropped
    assign ack_ok      = memresp_val && (memresp_msg.type_ == MEM_TYPE_WRITE) && (outst_q != 5'd0);
    assign can_send    = (send_idx_q < 5'd16) && (outst_q < 5'(MAX_OUTSTANDING));
    assign empty       = (count_q == '0) && (outst_q == 5'd0);

    lab3_cache_wbb_entry_file #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_entries (
        .clk        (clk),
        .reset      (reset),
        .wr_en_i    (enq),
        .wr_ptr_i   (tail_q),
        .wr_line_i  (evict_addr[31:OFFSET_BITS]),
        .wr_data_i  (evict_data),
        .clr_en_i   (retire),
        .head_ptr_i (head_q),
        .head_o     (head_ent),
        .chk_line_i (check_addr[31:OFFSET_BITS]),
        .chk_hit_o  (check_hit)
`ifdef LAB3_CACHE_WBB_FORWARD_EN
        ,
        .fwd_data_o (fwd_data)
`endif
    );

`ifdef LAB3_CACHE_WBB_FORWARD_EN
    assign fwd_val = check_hit;
`endif

    // Sender FSM: IDLE already offers word 0 so the first request follows enqueue by one cycle
    always_comb begin
        state_d    = state_q;
        memreq_val = 1'b0;
        retire     = 1'b0;
        case (state_q)
            IDLE: begin
                if (head_ent.valid) begin
                    memreq_val = can_send;
                    state_d    = SEND;
                end
            end
            SEND: begin
                memreq_val = can_send;
                if (can_send && memreq_rdy && (send_idx_q == 5'd15)) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (ack_cnt_q == 5'd16) begin
                    retire  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request payload for the current head word; zero whenever nothing is offered
    always_comb begin
        memreq_msg = '0;
        if (memreq_val) begin
            memreq_msg.type_  = MEM_TYPE_WRITE;
            memreq_msg.opaque = {4'(head_q), send_idx_q[3:0]};
            memreq_msg.addr   = {head_ent.line_addr, send_idx_q[3:0], 2'b00};
            memreq_msg.len    = 2'd0;
            memreq_msg.data   = head_ent.data[{send_idx_q[3:0], 5'd0} +: 32];
        end
    end

    // Pointer, occupancy and per-head progress counters; retirement restarts the counters for the next head
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        send_idx_d = send_idx_q;
        ack_cnt_d  = ack_cnt_q;
        outst_d    = outst_q;
        if (enq) begin
            tail_d = ptr_inc(tail_q);
        end
        if (retire) begin
            head_d     = ptr_inc(head_q);
            send_idx_d = 5'd0;
            ack_cnt_d  = 5'd0;
        end else begin
            if (fire) begin
                send_idx_d = send_idx_q + 5'd1;
            end
            if (ack_ok) begin
                ack_cnt_d = ack_cnt_q + 5'd1;
            end
        end
        case ({enq, retire})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        case ({fire, ack_ok})
            2'b10:   outst_d = outst_q + 5'd1;
            2'b01:   outst_d = outst_q - 5'd1;
            default: outst_d = outst_q;
        endcase
    end

    // State registers with synchronous reset, which also abandons any drain in progress
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            send_idx_q <= 5'd0;
            ack_cnt_q  <= 5'd0;
            outst_q    <= 5'd0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            send_idx_q <= send_idx_d;
            ack_cnt_q  <= ack_cnt_d;
            outst_q    <= outst_d;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{evict_addr[OFFSET_BITS-1:0], check_addr[OFFSET_BITS-1:0],
                           memresp_msg.opaque, memresp_msg.test, memresp_msg.len, memresp_msg.data};

endmodule

// File: tb/tb_lab3_cache_writeback_buffer.sv
// Scoreboard bench for the write-back buffer with a word-level reference model.
// Latency: n/a.
// Backpressure: memreq_rdy and ack timing are driven in several modes, including random.
module tb_lab3_cache_writeback_buffer;
    import lab3_cache_pkg::*;

    localparam int DEPTH = 2;
    localparam int MAXO  = 16;

    logic           clk = 1'b0;
    logic           reset;
    logic           evict_val, evict_rdy;
    logic [31:0]    evict_addr;
    logic [511:0]   evict_data;
    logic           memreq_val, memreq_rdy;
    mem_req_4B_t    memreq_msg;
    logic           memresp_val, memresp_rdy;
    mem_resp_4B_t   memresp_msg;
    logic [31:0]    check_addr;
    logic           check_hit, empty;
`ifdef LAB3_CACHE_WBB_FORWARD_EN
    logic           fwd_val;
    logic [511:0]   fwd_data;
`endif

    lab3_cache_writeback_buffer #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
        .clk         (clk),
        .reset       (reset),
        .evict_val   (evict_val),
        .evict_rdy   (evict_rdy),
        .evict_addr  (evict_addr),
        .evict_data  (evict_data),
        .memreq_val  (memreq_val),
        .memreq_rdy  (memreq_rdy),
        .memreq_msg  (memreq_msg),
        .memresp_val (memresp_val),
        .memresp_rdy (memresp_rdy),
        .memresp_msg (memresp_msg),
        .check_addr  (check_addr),
        .check_hit   (check_hit),
        .empty       (empty)
`ifdef LAB3_CACHE_WBB_FORWARD_EN
        ,
        .fwd_val     (fwd_val),
        .fwd_data    (fwd_data)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         due;
        logic [7:0] opaque;
    } ack_t;

    mem_req_4B_t expq[$];
    ack_t        ackq[$];
    int          line_done[$];
    int n_chk = 0, n_pass = 0, n_fail = 0;
    int rdy_mode = 0, dmin = 1, dmax = 1, stray = 0, fires = 0, acks_total = 0, slot = 0, last_due = 0;
    bit bogus_en = 1'b0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: an accepted line becomes 16 ascending word writes tagged with its slot
    function automatic void model_enqueue(input logic [31:0] a, input logic [511:0] d);
        mem_req_4B_t m;
        for (int i = 0; i < LINE_WORDS; i++) begin
            m        = '0;
            m.type_  = MEM_TYPE_WRITE;
            m.opaque = {4'(slot), 4'(i)};
            m.addr   = {a[31:6], 4'(i), 2'b00};
            m.len    = 2'd0;
            m.data   = d[32*i +: 32];
            expq.push_back(m);
        end
        slot = (slot + 1) % DEPTH;
    endfunction

    function automatic logic [511:0] rand_line();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic evict(input logic [31:0] a, input logic [511:0] d, output int fcyc);
        int n = 0;
        fcyc = -1;
        evict_val = 1'b1; evict_addr = a; evict_data = d;
        while (fcyc < 0 && n < 2000) begin
            @(negedge clk);
            if (evict_rdy) begin
                fcyc = cyc;
                model_enqueue(a, d);
            end
            @(posedge clk); #1;
            n++;
        end
        evict_val = 1'b0; evict_addr = $urandom; evict_data = '0;
        if (fcyc < 0) chk("evict_timeout_rdy", evict_rdy, 1'b1);
    endtask

    task automatic wait_empty(input string name, input int budget, output int ecyc);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!empty && n < budget);
        ecyc = cyc;
        chk({name, "_empty"}, empty, 1'b1);
        chk({name, "_reqs_left"}, expq.size(), 0);
        chk({name, "_acks_left"}, ackq.size(), 0);
    endtask

    // memreq_rdy driver
    initial begin
        memreq_rdy = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       memreq_rdy = 1'b1;
                1:       memreq_rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
                2:       memreq_rdy = ($urandom_range(0, 1) == 1);
                default: memreq_rdy = 1'b0;
            endcase
        end
    end

    // Memory responder: in-order acks at scheduled cycles, stray acks, optional non-write noise
    initial begin
        ack_t a;
        memresp_val = 1'b0;
        memresp_msg = '0;
        forever begin
            @(posedge clk); #1;
            memresp_val = 1'b0;
            memresp_msg = '0;
            if (ackq.size() > 0 && ackq[0].due <= cyc) begin
                a = ackq.pop_front();
                memresp_val        = 1'b1;
                memresp_msg.type_  = MEM_TYPE_WRITE;
                memresp_msg.opaque = a.opaque;
                memresp_msg.data   = $urandom;
                acks_total++;
                if (acks_total % 16 == 0) line_done.push_back(cyc);
            end else if (stray > 0) begin
                memresp_val       = 1'b1;
                memresp_msg.type_ = MEM_TYPE_WRITE;
                stray--;
            end else if (bogus_en && $urandom_range(0, 3) == 0) begin
                memresp_val       = 1'b1;
                memresp_msg.type_ = MEM_TYPE_READ;
            end
        end
    end

    // Monitor: pops the scoreboard on every request fire, checks stall stability
    initial begin
        mem_req_4B_t prev_msg, e;
        bit          prev_stall = 1'b0;
        int          due;
        forever begin
            @(negedge clk);
            if (reset !== 1'b0) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("stall_val_held", memreq_val, 1'b1);
                    chk("stall_msg_held", memreq_msg, prev_msg);
                end
                if (!memreq_val) chk("idle_msg_zero", memreq_msg, '0);
                if (memreq_val && memreq_rdy) begin
                    fires++;
                    if (expq.size() == 0) begin
                        chk("unexpected_req", memreq_val, 1'b0);
                    end else begin
                        e = expq.pop_front();
                        chk("req_msg", memreq_msg, e);
                        due = cyc + int'($urandom_range(dmin, dmax));
                        if (due <= last_due) due = last_due + 1;
                        last_due = due;
                        ackq.push_back('{due: due, opaque: e.opaque});
                    end
                end
                prev_stall = memreq_val && !memreq_rdy;
                prev_msg   = memreq_msg;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int f, fa, fb, fc, f0, n0, ec, n;
        logic [511:0] d, d_old, d_new;
        reset = 1'b1; evict_val = 1'b0; evict_addr = '0; evict_data = '0; check_addr = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_memreq_val", memreq_val, 1'b0);
        chk("rst_evict_rdy", evict_rdy, 1'b1);
        chk("rst_check_hit", check_hit, 1'b0);
        chk("rst_empty", empty, 1'b1);
        chk("rst_memreq_msg", memreq_msg, '0);
        chk("memresp_rdy", memresp_rdy, 1'b1);

        // Single eviction
        for (int i = 0; i < 16; i++) d[32*i +: 32] = 32'hA000_0000 + 32'(i);
        rdy_mode = 0; dmin = 1; dmax = 1; f0 = fires;
        @(posedge clk); #1;
        evict(32'h0000_1040, d, f);
        @(negedge clk);
        chk("first_req_next_cycle", memreq_val, 1'b1);
        wait_empty("single", 200, ec);
        chk("single_fires", fires - f0, 16);
        if (line_done.size() > 0) chk("single_empty_timing", ec, line_done[line_done.size() - 1] + 2);
        else chk("single_line_done", line_done.size(), 1);

        // Address check while a line is pending, then after it retires
        rdy_mode = 3;
        @(posedge clk); #1;
        evict(32'h0000_2000, rand_line(), f);
        check_addr = 32'h0000_203C;
        @(negedge clk);
        chk("hit_pending", check_hit, 1'b1);
        check_addr = 32'h0000_2040;
        @(negedge clk);
        chk("miss_next_line", check_hit, 1'b0);
        check_addr = 32'h0000_203C;
        rdy_mode = 0;
        wait_empty("addrchk", 300, ec);
        chk("miss_after_retire", check_hit, 1'b0);

        // Backpressure pattern 1,0,0,1
        rdy_mode = 1; f0 = fires;
        @(posedge clk); #1;
        evict(32'h0000_4A00, rand_line(), f);
        wait_empty("bp", 300, ec);
        chk("bp_fires", fires - f0, 16);

        // Full buffer with slow acks
        rdy_mode = 0; dmin = 20; dmax = 20; n0 = line_done.size();
        @(posedge clk); #1;
        evict(32'h0001_0000, rand_line(), fa);
        evict(32'h0001_0040, rand_line(), fb);
        @(negedge clk);
        chk("full_rdy_low", evict_rdy, 1'b0);
        @(posedge clk); #1;
        evict(32'h0001_0080, rand_line(), fc);
        if (line_done.size() > n0) chk("third_accept_cycle", fc, line_done[n0] + 2);
        else chk("third_after_retire", line_done.size(), n0 + 1);
        wait_empty("full", 600, ec);

`ifdef LAB3_CACHE_WBB_FORWARD_EN
        rdy_mode = 3; dmin = 1; dmax = 1;
        d_old = rand_line(); d_new = rand_line();
        @(posedge clk); #1;
        evict(32'h0000_3000, d_old, f);
        evict(32'h0000_3000, d_new, f);
        check_addr = 32'h0000_3000;
        @(negedge clk);
        chk("fwd_val", fwd_val, 1'b1);
        chk("fwd_data_newest", fwd_data, d_new);
        rdy_mode = 0;
        wait_empty("fwd", 400, ec);
`else
        d_old = '0; d_new = '0;
`endif

        // Randomized traffic with random ready, ack delays and non-write noise
        rdy_mode = 2; dmin = 1; dmax = 6; bogus_en = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 6; k++) evict($urandom, rand_line(), f);
        wait_empty("random", 3000, ec);
        bogus_en = 1'b0;

        // Reset mid-drain followed by stray acks
        rdy_mode = 0; dmin = 200; dmax = 200; f0 = fires; n = 0;
        @(posedge clk); #1;
        evict(32'h0000_5000, rand_line(), f);
        while (fires - f0 < 5 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("pre_reset_fires", (fires - f0 >= 5), 1'b1);
        @(posedge clk); #1;
        reset = 1'b1; rdy_mode = 3;
        @(posedge clk); #1;
        reset = 1'b0;
        expq.delete(); ackq.delete(); line_done.delete();
        last_due = 0; slot = 0; acks_total = 0; stray = 3;
        @(negedge clk);
        chk("mid_rst_empty", empty, 1'b1);
        chk("mid_rst_memreq_val", memreq_val, 1'b0);
        chk("mid_rst_evict_rdy", evict_rdy, 1'b1);
        repeat (6) @(negedge clk);
        chk("stray_acks_ignored", empty, 1'b1);
        rdy_mode = 0; dmin = 1; dmax = 1;
        @(posedge clk); #1;
        evict(32'h0000_6000, rand_line(), f);
        wait_empty("post_reset", 200, ec);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/lab3_cache_writeback_buffer.md
Name: lab3_cache_writeback_buffer

Overview:
- Victim buffer between the cache datapath's M0 eviction path and the 4B memory port.
- Accepts a full dirty 512-bit line plus its line address in one cycle, so the cache controller can start its refill immediately.
- Drains the line as 16 single-word write requests and retires it after all 16 write acks return.
- Exposes an address-match check so the controller never refills a line that is still pending write-back.

Parameters:
- DEPTH, 2, number of victim line entries; must be a power of two, 1..4.
- MAX_OUTSTANDING, 16, maximum write requests in flight without an ack (1..16).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- evict_val  in  1  eviction line valid
- evict_rdy  out  1  a free entry exists
- evict_addr  in  32  line address; bits [5:0] are ignored and forced to 0
- evict_data  in  512  line data; word i = bits [32i+31:32i]
- memreq_val  out  1  write request valid
- memreq_rdy  in  1  memory accepts request
- memreq_msg  out  77  mem_req_4B_t
- memresp_val  in  1  write ack valid
- memresp_rdy  out  1  constant 1
- memresp_msg  in  47  mem_resp_4B_t
- check_addr  in  32  line address to check against pending entries
- check_hit  out  1  check_addr[31:6] matches a valid entry
- empty  out  1  no valid entries and no outstanding acks

Behaviour:
- Entries form a circular FIFO: head/tail pointers of log2(DEPTH) bits plus a count of 0..DEPTH. Pointers wrap modulo DEPTH.
- Enqueue fires when evict_val && evict_rdy. The entry is written at tail with valid=1, send_idx=0, ack_cnt=0.
- evict_rdy = (count < DEPTH). It is purely combinational on registered state and does not depend on same-cycle retirement.
- Sender state machine runs on the head entry only.
  - IDLE: go to SEND when the head entry is valid.
  - SEND: memreq_val=1 while send_idx<16 and outstanding<MAX_OUTSTANDING.
    - Each fire increments send_idx and outstanding.
    - Go to WAIT when send_idx reaches 16 on a fire.
  - WAIT: memreq_val=0 until ack_cnt==16. Then retire the head: valid=0, head++, count--, return to IDLE.
  - Retirement and acceptance of the next head's first request never occur in the same cycle.
- memreq_msg fields:
  - type_ = WRITE
  - opaque = {ptr zero-extended to 4 bits, send_idx[3:0]}
  - addr = {line[31:6], send_idx[3:0], 2'b00}
  - len = 0
  - data = word send_idx
- Requests within a line issue in ascending word order. First request is valid the cycle after enqueue; throughput is 1 request per cycle while memreq_rdy=1.
- Each memresp_val increments the head's ack_cnt and decrements outstanding.
  - Responses are in order for the head line; opaque[7:4] is not checked.
  - A response with outstanding==0 is ignored.
  - A response with type_ != WRITE is ignored.
- Simultaneous events:
  - Enqueue while count==DEPTH: impossible, since rdy=0.
  - Enqueue in the retirement cycle: both apply; count is unchanged.
  - Request fire and ack in the same cycle: outstanding is unchanged.
- check_hit is combinational over all valid entries, including the head in WAIT.
- empty = (count==0) && (outstanding==0).
- Reset values (applied on reset, including mid-drain):
  - all valid=0; head=tail=count=0; outstanding=0; state IDLE
  - memreq_val=0, evict_rdy=1, check_hit=0, empty=1
  - memreq_msg driven to 0 when not valid
  - Post-reset stray acks are ignored per the outstanding==0 rule.

Optional Feature:
- LAB3_CACHE_WBB_FORWARD_EN: adds outputs fwd_val (1) and fwd_data (512).
  - On check_hit, fwd_val=1 and fwd_data = the newest matching entry's line, searched tail-1 toward head.
  - The controller uses this data as the refill in place of a memory read.
- Without the macro: no fwd ports; the controller must stall its refill while check_hit=1.

Decomposition:
- Shared package lab3_cache_pkg holds:
  - LINE_WORDS=16, LINE_BITS=512, OFFSET_BITS=6
  - the wbb state enum {IDLE, SEND, WAIT}
  - the entry struct {valid, line_addr[25:0], data[511:0]}
  - mem_req_4B_t / mem_resp_4B_t, reused from the mem-msgs include
- One natural sub-module: lab3_cache_wbb_entry_file, a DEPTH x entry storage with one write port, head read, and a parallel address compare.

Test Plan:
- Single eviction:
  - Stimulus: addr 0x00001040, word i = 0xA0000000+i, memreq_rdy=1, ack one cycle after each request.
  - Response: 16 writes at addr 0x1040..0x107C with data 0xA0000000..0xA000000F and opaque 0x00..0x0F; empty returns 1 after the 16th ack.
- Full buffer:
  - Stimulus: DEPTH=2, three back-to-back evictions, acks delayed 20 cycles.
  - Response: evict_rdy=0 after the second; the third accepted only in the first cycle after head retirement; line order preserved.
- Backpressure:
  - Stimulus: memreq_rdy toggles 1,0,0,1.
  - Response: memreq_msg stable while val && !rdy; no word skipped or duplicated; exactly 16 fires.
- Address check:
  - Stimulus: pending line 0x00002000, check_addr 0x0000203C.
  - Response: check_hit=1. With check_addr 0x00002040: check_hit=0. After retirement: check_hit=0.
- Reset mid-drain:
  - Stimulus: reset after 5 fires; 3 stray acks arrive afterward.
  - Response: empty=1 and memreq_val=0 the cycle after reset; stray acks are ignored; a new eviction drains normally from word 0.
- LAB3_CACHE_WBB_FORWARD_EN:
  - Stimulus: two entries for line 0x3000 (old, then new), check_addr 0x3000.
  - Response: fwd_val=1 and fwd_data equals the newer line.
